data_memory_ctrl: RTL

Parametrised byte-addressable data memory for the RV32IC core's load/store stage, successor to the single-cycle Memory block. Adds configurable depth, a valid/ready request handshake, registered read responses, load sign/zero extension, and a two-cycle split sequence for accesses that cross a word boundary. It sits between the execute stage's load/store unit and the word-organised storage array.

---
 rtl/data_memory_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressable little-endian data memory for the load/store
// stage. It uses a valid/ready request handshake and registered responses, and
// handles word-crossing accesses as a two-cycle split sequence.
module data_memory_ctrl #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter bit          MISALIGN_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_valid,
    output logic        mem_req_ready,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_rsp_valid,
    output logic [31:0] mem_rdata,
    output logic        mem_rsp_err
);

    localparam int unsigned AW         = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t        state;
    logic [31:0]   mem_array [DEPTH_WORDS];

    // request decode
    logic          accept;
    logic [1:0]    off;
    logic [3:0]    nbytes;
    logic [3:0]    base_be;
    logic [32:0]   last_byte;
    logic          crossing;
    logic          req_err;
    logic [AW-1:0] lo_idx;
    logic [AW-1:0] hi_idx;
    logic [7:0]    be64;
    logic [63:0]   wd64;
    logic [31:0]   lo_raw;

    // state latched for the second half of a split access
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          write_q;
    logic [AW-1:0] hi_idx_q;
    logic [3:0]    hi_be_q;
    logic [31:0]   hi_wd_q;
    logic [31:0]   lo_raw_q;

    // Shift the addressed bytes down to bit 0, then zero- or sign-extend them.
    function automatic logic [31:0] extend_load(input logic [63:0] raw,
                                                input logic [1:0]  o,
                                                input logic [1:0]  sz,
                                                input logic        uns);
        logic [31:0] s;
        s = 32'(raw >> {o, 3'b000});
        case (sz)
            2'd0:    extend_load = uns ? {24'h0, s[7:0]}  : {{24{s[7]}},  s[7:0]};
            2'd1:    extend_load = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
            default: extend_load = s;
        endcase
    endfunction

    // Decode the incoming request: byte lanes, word crossing and error conditions.
    always_comb begin
        accept = mem_req_valid && mem_req_ready;
        off    = mem_addr[1:0];
        case (mem_size)
            2'd0:    begin nbytes = 4'd1; base_be = 4'b0001; end
            2'd1:    begin nbytes = 4'd2; base_be = 4'b0011; end
            default: begin nbytes = 4'd4; base_be = 4'b1111; end
        endcase
        last_byte = {1'b0, mem_addr} + 33'(nbytes - 4'd1);
        crossing  = ({2'b00, off} + nbytes) > 4'd4;
        req_err   = (mem_size == 2'd3) || (last_byte >= BYTE_LIMIT) ||
                    (crossing && !MISALIGN_SPLIT);
        lo_idx    = mem_addr[AW+1:2];
        hi_idx    = lo_idx + AW'(1);
        be64      = {4'b0000, base_be} << off;
        wd64      = {32'h0, mem_wdata} << {off, 3'b000};
        lo_raw    = mem_array[lo_idx];
    end

    // Storage array: low-word lanes are written at accept, high-word lanes in SECOND.
    always_ff @(posedge clk) begin
        if (accept && !req_err && mem_write) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be64[i]) mem_array[lo_idx][8*i +: 8] <= wd64[8*i +: 8];
            end
        end
        if (state == SECOND && write_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (hi_be_q[i]) mem_array[hi_idx_q][8*i +: 8] <= hi_wd_q[8*i +: 8];
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            mem_req_ready <= 1'b1;
            mem_rsp_valid <= 1'b0;
            mem_rdata     <= '0;
            mem_rsp_err   <= 1'b0;
            off_q         <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            write_q       <= 1'b0;
            hi_idx_q      <= '0;
            hi_be_q       <= '0;
            hi_wd_q       <= '0;
            lo_raw_q      <= '0;
        end else begin
            mem_rsp_valid <= 1'b0;
            mem_rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            mem_rsp_valid <= 1'b1;
                            mem_rsp_err   <= 1'b1;
                            mem_rdata     <= '0;
                        end else if (crossing) begin
                            state         <= SECOND;
                            mem_req_ready <= 1'b0;
                            off_q         <= off;
                            size_q        <= mem_size;
                            uns_q         <= mem_unsigned;
                            write_q       <= mem_write;
                            hi_idx_q      <= hi_idx;
                            hi_be_q       <= be64[7:4];
                            hi_wd_q       <= wd64[63:32];
                            lo_raw_q      <= lo_raw;
                        end else begin
                            mem_rsp_valid <= 1'b1;
                            mem_rdata     <= mem_write ? '0 :
                                extend_load({32'h0, lo_raw}, off, mem_size, mem_unsigned);
                        end
                    end
                end
                SECOND: begin
                    state         <= IDLE;
                    mem_req_ready <= 1'b1;
                    mem_rsp_valid <= 1'b1;
                    mem_rdata     <= write_q ? '0 :
                        extend_load({mem_array[hi_idx_q], lo_raw_q}, off_q, size_q, uns_q);
                end
                default: begin
                    state         <= IDLE;
                    mem_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
